// File: rtl/ex_if.sv
// ex_if: bundles the pipeline-facing signals of the MIPS execute stage.
//   stall           : stall vector from CTRL (bit 2 = ID/EX, bit 3 = EX/MEM)
//   stallreq_for_ex : EX asks CTRL to freeze the front of the pipe
//   id_to_ex_bus    : decoded instruction from ID (159 bits)
//   ex_to_mem_bus   : result bundle to MEM (142 bits)
//   data_sram_*     : data-SRAM request issued from EX
//   ex_wreg/ex_waddr/ex_wdata/ex_opl : forwarding info back to ID
// The slave modport is the EX stage itself; master is its surroundings.
interface ex_if;
    logic [5:0]   stall;
    logic         stallreq_for_ex;
    logic [158:0] id_to_ex_bus;
    logic [141:0] ex_to_mem_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         ex_wreg;
    logic [4:0]   ex_waddr;
    logic [31:0]  ex_wdata;
    logic         ex_opl;

    modport slave (
        input  stall,
        input  id_to_ex_bus,
        output stallreq_for_ex,
        output ex_to_mem_bus,
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        output ex_wreg,
        output ex_waddr,
        output ex_wdata,
        output ex_opl
    );

    modport master (
        output stall,
        output id_to_ex_bus,
        input  stallreq_for_ex,
        input  ex_to_mem_bus,
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        input  ex_wreg,
        input  ex_waddr,
        input  ex_wdata,
        input  ex_opl
    );
endinterface

// File: rtl/ex.sv
// ex: execute stage of the five-stage MIPS pipeline.
//   clk  : pipeline clock, all state on posedge
//   rst  : synchronous active-high reset
//   pipe : ex_if.slave -- stall/id_to_ex_bus in; ex_to_mem_bus, data-SRAM
//          request, forwarding outputs and stallreq_for_ex out
// The ID-to-EX register feeds a combinational 12-function ALU, so ordinary
// instructions spend one cycle here. DIV/DIVU run a 32-step restoring
// divider and hold the pipe through stallreq_for_ex until HI/LO are ready.
module ex (
    input  logic clk,
    input  logic rst,
    ex_if.slave  pipe
);
    localparam int unsigned ID_TO_EX_WD = 159;
    localparam logic        STOP        = 1'b1;
    localparam logic        NO_STOP     = 1'b0;

    // One-hot ALU opcodes, msb first: add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui
    localparam logic [11:0] OP_ADD  = 12'b1000_0000_0000;
    localparam logic [11:0] OP_SUB  = 12'b0100_0000_0000;
    localparam logic [11:0] OP_SLT  = 12'b0010_0000_0000;
    localparam logic [11:0] OP_SLTU = 12'b0001_0000_0000;
    localparam logic [11:0] OP_AND  = 12'b0000_1000_0000;
    localparam logic [11:0] OP_NOR  = 12'b0000_0100_0000;
    localparam logic [11:0] OP_OR   = 12'b0000_0010_0000;
    localparam logic [11:0] OP_XOR  = 12'b0000_0001_0000;
    localparam logic [11:0] OP_SLL  = 12'b0000_0000_1000;
    localparam logic [11:0] OP_SRL  = 12'b0000_0000_0100;
    localparam logic [11:0] OP_SRA  = 12'b0000_0000_0010;
    localparam logic [11:0] OP_LUI  = 12'b0000_0000_0001;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // ------------------------------------------------------------------
    // ID-to-EX register
    // ------------------------------------------------------------------
    logic [ID_TO_EX_WD-1:0] id_to_ex_r;

    // Pipeline register: bubble when ID stalls but EX moves on, else load or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_to_ex_r <= {ID_TO_EX_WD{1'b0}};
        end else if (pipe.stall[2] == STOP && pipe.stall[3] == NO_STOP) begin
            id_to_ex_r <= {ID_TO_EX_WD{1'b0}};
        end else if (pipe.stall[2] == NO_STOP) begin
            id_to_ex_r <= pipe.id_to_ex_bus;
        end else begin
            id_to_ex_r <= id_to_ex_r;
        end
    end

    logic [31:0] pc_s;
    logic [31:0] inst_s;
    logic [11:0] alu_op_s;
    logic [2:0]  sel_src1_s;
    logic [3:0]  sel_src2_s;
    logic        ram_en_s;
    logic [3:0]  ram_wen_s;
    logic        rf_we_s;
    logic [4:0]  rf_waddr_s;
    logic        sel_rf_res_s;
    logic [31:0] rdata1_s;
    logic [31:0] rdata2_s;

    assign pc_s         = id_to_ex_r[158:127];
    assign inst_s       = id_to_ex_r[126:95];
    assign alu_op_s     = id_to_ex_r[94:83];
    assign sel_src1_s   = id_to_ex_r[82:80];
    assign sel_src2_s   = id_to_ex_r[79:76];
    assign ram_en_s     = id_to_ex_r[75];
    assign ram_wen_s    = id_to_ex_r[74:71];
    assign rf_we_s      = id_to_ex_r[70];
    assign rf_waddr_s   = id_to_ex_r[69:65];
    assign sel_rf_res_s = id_to_ex_r[64];
    assign rdata1_s     = id_to_ex_r[63:32];
    assign rdata2_s     = id_to_ex_r[31:0];

    // ------------------------------------------------------------------
    // Operand selection and ALU
    // ------------------------------------------------------------------
    logic [31:0] src1_s;
    logic [31:0] src2_s;
    logic [31:0] alu_res_s;

    // First operand: register, pc (link address) or shift amount.
    always_comb begin
        src1_s = rdata1_s;
        if (sel_src1_s[1]) begin
            src1_s = pc_s;
        end else if (sel_src1_s[2]) begin
            src1_s = {27'b0, inst_s[10:6]};
        end else begin
            src1_s = rdata1_s;
        end
    end

    // Second operand: register, sign/zero-extended immediate, or the link offset 8.
    always_comb begin
        src2_s = rdata2_s;
        if (sel_src2_s[1]) begin
            src2_s = {{16{inst_s[15]}}, inst_s[15:0]};
        end else if (sel_src2_s[2]) begin
            src2_s = 32'd8;
        end else if (sel_src2_s[3]) begin
            src2_s = {16'h0000, inst_s[15:0]};
        end else begin
            src2_s = rdata2_s;
        end
    end

    // ALU: shifts move src2 by src1[4:0]; an unknown or empty opcode yields zero.
    always_comb begin
        alu_res_s = 32'h0000_0000;
        case (alu_op_s)
            OP_ADD:  alu_res_s = src1_s + src2_s;
            OP_SUB:  alu_res_s = src1_s - src2_s;
            OP_SLT:  alu_res_s = ($signed(src1_s) < $signed(src2_s)) ? 32'd1 : 32'd0;
            OP_SLTU: alu_res_s = (src1_s < src2_s) ? 32'd1 : 32'd0;
            OP_AND:  alu_res_s = src1_s & src2_s;
            OP_NOR:  alu_res_s = ~(src1_s | src2_s);
            OP_OR:   alu_res_s = src1_s | src2_s;
            OP_XOR:  alu_res_s = src1_s ^ src2_s;
            OP_SLL:  alu_res_s = src2_s << src1_s[4:0];
            OP_SRL:  alu_res_s = src2_s >> src1_s[4:0];
            OP_SRA:  alu_res_s = $signed(src2_s) >>> src1_s[4:0];
            OP_LUI:  alu_res_s = {src2_s[15:0], 16'h0000};
            default: alu_res_s = 32'h0000_0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    logic        div_op_s;
    logic        div_signed_s;
    logic        divisor_zero_s;
    logic [31:0] abs1_s;
    logic [31:0] abs2_s;

    assign div_op_s       = (inst_s[31:26] == 6'h00) &&
                            ((inst_s[5:0] == 6'h1A) || (inst_s[5:0] == 6'h1B));
    assign div_signed_s   = (inst_s[5:0] == 6'h1A);
    assign divisor_zero_s = (rdata2_s == 32'h0000_0000);
    // Magnitudes; 0x80000000 negates to itself, which is correct as unsigned.
    assign abs1_s = (div_signed_s && rdata1_s[31]) ? (~rdata1_s + 32'd1) : rdata1_s;
    assign abs2_s = (div_signed_s && rdata2_s[31]) ? (~rdata2_s + 32'd1) : rdata2_s;

    div_state_e  state_r;
    div_state_e  state_next_s;
    logic [4:0]  cnt_r;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] dsr_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic        dz_r;

    // Divider state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Divider next-state: zero divisor skips the iterations entirely.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (div_op_s) begin
                    state_next_s = divisor_zero_s ? DIV_DONE : DIV_RUN;
                end else begin
                    state_next_s = DIV_IDLE;
                end
            end
            DIV_RUN: begin
                if (cnt_r == 5'd31) begin
                    state_next_s = DIV_DONE;
                end else begin
                    state_next_s = DIV_RUN;
                end
            end
            DIV_DONE: begin
                if (pipe.stall[3] == STOP) begin
                    state_next_s = DIV_DONE;
                end else begin
                    state_next_s = DIV_IDLE;
                end
            end
            default: state_next_s = DIV_IDLE;
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. 34 bits keep the borrow.
    logic [32:0] shifted_s;
    logic [33:0] diff_s;
    logic        borrow_s;
    logic [31:0] rem_step_s;
    logic [31:0] quo_step_s;

    assign shifted_s  = {rem_r, quo_r[31]};
    assign diff_s     = {1'b0, shifted_s} - {2'b00, dsr_r};
    assign borrow_s   = diff_s[33];
    assign rem_step_s = borrow_s ? shifted_s[31:0] : diff_s[31:0];
    assign quo_step_s = {quo_r[30:0], ~borrow_s};

    // Divider datapath: capture operands on entry, iterate while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= 5'd0;
            quo_r   <= 32'h0000_0000;
            rem_r   <= 32'h0000_0000;
            dsr_r   <= 32'h0000_0000;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (div_op_s) begin
                        cnt_r   <= 5'd0;
                        quo_r   <= abs1_s;
                        rem_r   <= 32'h0000_0000;
                        dsr_r   <= abs2_s;
                        neg_q_r <= div_signed_s & (rdata1_s[31] ^ rdata2_s[31]);
                        neg_r_r <= div_signed_s & rdata1_s[31];
                        dz_r    <= divisor_zero_s;
                    end
                end
                DIV_RUN: begin
                    cnt_r <= cnt_r + 5'd1;
                    quo_r <= quo_step_s;
                    rem_r <= rem_step_s;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;
    logic        hi_we_s;
    logic        lo_we_s;
    logic [31:0] hi_s;
    logic [31:0] lo_s;

    assign quo_fix_s = neg_q_r ? (~quo_r + 32'd1) : quo_r;
    assign rem_fix_s = neg_r_r ? (~rem_r + 32'd1) : rem_r;

    // HI/LO write-back: only a finished divide drives them; divide-by-zero
    // returns all-ones quotient and the untouched dividend as remainder.
    always_comb begin
        hi_we_s = 1'b0;
        lo_we_s = 1'b0;
        hi_s    = 32'h0000_0000;
        lo_s    = 32'h0000_0000;
        if (state_r == DIV_DONE && div_op_s) begin
            hi_we_s = 1'b1;
            lo_we_s = 1'b1;
            if (dz_r) begin
                lo_s = 32'hFFFF_FFFF;
                hi_s = rdata1_s;
            end else begin
                lo_s = quo_fix_s;
                hi_s = rem_fix_s;
            end
        end else begin
            hi_we_s = 1'b0;
            lo_we_s = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pipe.stallreq_for_ex = div_op_s && (state_r != DIV_DONE);

    assign pipe.ex_to_mem_bus = {pc_s, ram_en_s, ram_wen_s, sel_rf_res_s, rf_we_s,
                                 rf_waddr_s, alu_res_s, hi_we_s, lo_we_s, hi_s, lo_s};

    assign pipe.data_sram_en    = ram_en_s;
    assign pipe.data_sram_wen   = ram_wen_s;
    assign pipe.data_sram_addr  = alu_res_s;
    assign pipe.data_sram_wdata = rdata2_s;

    assign pipe.ex_wreg  = rf_we_s;
    assign pipe.ex_waddr = rf_waddr_s;
    assign pipe.ex_wdata = alu_res_s;
    // A load is a RAM access with no write strobes whose result comes from memory.
    assign pipe.ex_opl   = ram_en_s & ~(|ram_wen_s) & sel_rf_res_s;

    // Bits this stage does not consume.
    logic unused_s;
    assign unused_s = &{1'b0, pipe.stall[5:4], pipe.stall[1:0], inst_s[25:16], diff_s[32]};

endmodule

// File: tb/tb_ex.sv
// tb_ex: directed scoreboard bench for the execute stage. Stimulus pushes the
// hand-computed expected response when an instruction enters EX; a monitor
// pops and compares on each negedge where EX is not stalling, and also
// checks how many stall cycles preceded that response.
module tb_ex;
    logic clk;
    logic rst;
    logic [5:0] manual_stall;

    ex_if pipe ();

    ex dut (
        .clk  (clk),
        .rst  (rst),
        .pipe (pipe)
    );

    // CTRL model: a divide in EX freezes stall[3:0].
    assign pipe.stall = manual_stall | {2'b00, {4{pipe.stallreq_for_ex}}};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [141:0] mem;
        logic [68:0]  sram;
        logic [38:0]  fwd;
        int           stall;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] op;
        logic [2:0]  s1;
        logic [3:0]  s2;
        logic [4:0]  wa;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] res;
    } alu_vec_t;

    exp_t     sb[$];
    alu_vec_t alu_tab[13];
    int tests = 0;
    int fails = 0;

    function automatic logic [158:0] mk_id(
        input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
        input logic [2:0] s1, input logic [3:0] s2, input logic en, input logic [3:0] wen,
        input logic we, input logic [4:0] wa, input logic sel, input logic [31:0] r1,
        input logic [31:0] r2);
        return {pc, inst, op, s1, s2, en, wen, we, wa, sel, r1, r2};
    endfunction

    function automatic exp_t mk_exp(
        input logic [31:0] pc, input logic en, input logic [3:0] wen, input logic sel,
        input logic we, input logic [4:0] wa, input logic [31:0] res, input logic hilo_we,
        input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] wdata,
        input logic opl, input int stall);
        exp_t e;
        e.mem   = {pc, en, wen, sel, we, wa, res, hilo_we, hilo_we, hi, lo};
        e.sram  = {en, wen, res, wdata};
        e.fwd   = {we, wa, res, opl};
        e.stall = stall;
        return e;
    endfunction

    function automatic logic [158:0] alu_bus(input alu_vec_t v);
        return mk_id(v.pc, v.inst, v.op, v.s1, v.s2, 1'b0, 4'h0, 1'b1, v.wa, 1'b0, v.r1, v.r2);
    endfunction

    function automatic exp_t alu_exp(input alu_vec_t v);
        return mk_exp(v.pc, 1'b0, 4'h0, 1'b0, 1'b1, v.wa, v.res, 1'b0, 32'h0, 32'h0,
                      v.r2, 1'b0, 0);
    endfunction

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: compare whenever EX presents a result (not stalling).
    initial begin
        int   stall_cnt;
        exp_t e;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (pipe.stallreq_for_ex === 1'b1) begin
                stall_cnt++;
            end else if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ex_to_mem_bus", {18'h0, pipe.ex_to_mem_bus}, {18'h0, e.mem});
                chk("data_sram", {91'h0, pipe.data_sram_en, pipe.data_sram_wen,
                    pipe.data_sram_addr, pipe.data_sram_wdata}, {91'h0, e.sram});
                chk("forwarding", {121'h0, pipe.ex_wreg, pipe.ex_waddr, pipe.ex_wdata,
                    pipe.ex_opl}, {121'h0, e.fwd});
                if (e.stall >= 0) begin
                    chk("stall_cycles", 160'(stall_cnt), 160'(e.stall));
                end
                stall_cnt = 0;
            end
        end
    end

    // Present an instruction at a negedge and wait until EX accepts it.
    task automatic issue(input logic [158:0] b, input exp_t e, input bit push);
        int guard;
        pipe.id_to_ex_bus = b;
        guard = 0;
        while (pipe.stall[2] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: waited %0d cycles, limit 200", guard);
        end
        @(posedge clk);
        if (push) sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t zero_e;
        logic [158:0] lw_b;
        logic [158:0] div_b;
        zero_e = mk_exp(32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0,
                        32'h0, 1'b0, -1);
        //              pc            inst          op        s1      s2       wa     r1            r2            res
        alu_tab[0]  = '{32'hBFC00000, 32'h00221821, 12'h800, 3'b001, 4'b0001, 5'd3,  32'h7FFFFFFF, 32'h00000001, 32'h80000000}; // addu
        alu_tab[1]  = '{32'hBFC00008, 32'h00073103, 12'h002, 3'b100, 4'b0001, 5'd6,  32'h00000005, 32'hF0000000, 32'hFF000000}; // sra 4
        alu_tab[2]  = '{32'hBFC00010, 32'h016C502A, 12'h200, 3'b001, 4'b0001, 5'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000001}; // slt
        alu_tab[3]  = '{32'hBFC00014, 32'h016C502B, 12'h100, 3'b001, 4'b0001, 5'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000}; // sltu
        alu_tab[4]  = '{32'hBFC00024, 32'h3C0D1234, 12'h001, 3'b001, 4'b1000, 5'd13, 32'h00000000, 32'h00000000, 32'h12340000}; // lui
        alu_tab[5]  = '{32'h00000400, 32'h0C000000, 12'h800, 3'b010, 4'b0100, 5'd31, 32'h00000000, 32'h00000000, 32'h00000408}; // jal link
        alu_tab[6]  = '{32'h00000500, 32'h00221823, 12'h400, 3'b001, 4'b0001, 5'd3,  32'h00000005, 32'h00000007, 32'hFFFFFFFE}; // subu
        alu_tab[7]  = '{32'h00000504, 32'h3822FFFF, 12'h010, 3'b001, 4'b1000, 5'd2,  32'h12345678, 32'h00000000, 32'h1234A987}; // xori
        alu_tab[8]  = '{32'h00000508, 32'h00021200, 12'h008, 3'b100, 4'b0001, 5'd2,  32'hFFFFFFFF, 32'h000000FF, 32'h0000FF00}; // sll 8
        alu_tab[9]  = '{32'h0000050C, 32'h00221827, 12'h040, 3'b001, 4'b0001, 5'd3,  32'h0F0F0000, 32'h00F0000F, 32'hF000FFF0}; // nor
        alu_tab[10] = '{32'h00000510, 32'h00221824, 12'h080, 3'b001, 4'b0001, 5'd3,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00}; // and
        alu_tab[11] = '{32'h00000514, 32'h00221825, 12'h020, 3'b001, 4'b0001, 5'd3,  32'hFF00FF00, 32'h0FF00FF0, 32'hFFF0FFF0}; // or
        alu_tab[12] = '{32'h00000518, 32'h00021202, 12'h004, 3'b100, 4'b0001, 5'd2,  32'hFFFFFFFF, 32'hF0000000, 32'h00F00000}; // srl 8

        manual_stall      = 6'b000000;
        pipe.id_to_ex_bus = 159'h0;
        rst = 1'b1;
        @(posedge clk);
        sb.push_back(zero_e);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            issue(alu_bus(alu_tab[i]), alu_exp(alu_tab[i]), 1'b1);
        end

        // lw $4,-4($5) with base 0x100
        lw_b = mk_id(32'hBFC00004, 32'h8CA4FFFC, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1,
                     5'd4, 1'b1, 32'h00000100, 32'hDEADBEEF);
        issue(lw_b, mk_exp(32'hBFC00004, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h000000FC, 1'b0,
                           32'h0, 32'h0, 32'hDEADBEEF, 1'b1, 0), 1'b1);
        // sw $2,8($1)
        issue(mk_id(32'hBFC00028, 32'hAC220008, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0,
                    5'd0, 1'b0, 32'h00001000, 32'hCAFEF00D),
              mk_exp(32'hBFC00028, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h00001008, 1'b0,
                     32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 0), 1'b1);

        // DIV -7 / 2 -> lo=-3, hi=-1
        div_b = mk_id(32'hBFC0000C, 32'h0109001A, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0,
                      5'd0, 1'b0, 32'hFFFFFFF9, 32'h00000002);
        issue(div_b, mk_exp(32'hBFC0000C, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1,
                            32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000002, 1'b0, 33), 1'b1);
        // following instruction must see hi_we/lo_we cleared
        issue(alu_bus(alu_tab[0]), alu_exp(alu_tab[0]), 1'b1);

        // DIVU 0x1234 / 0
        issue(mk_id(32'hBFC00018, 32'h0109001B, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0,
                    5'd0, 1'b0, 32'h00001234, 32'h00000000),
              mk_exp(32'hBFC00018, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1,
                     32'h00001234, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1), 1'b1);
        // DIV 0x80000000 / -1, then DIVU 100 / 7 back to back
        issue(mk_id(32'hBFC0001C, 32'h0109001A, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0,
                    5'd0, 1'b0, 32'h80000000, 32'hFFFFFFFF),
              mk_exp(32'hBFC0001C, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1,
                     32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1'b0, 33), 1'b1);
        issue(mk_id(32'hBFC00020, 32'h0109001B, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0,
                    5'd0, 1'b0, 32'h00000064, 32'h00000007),
              mk_exp(32'hBFC00020, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1,
                     32'h00000002, 32'h0000000E, 32'h00000007, 1'b0, 33), 1'b1);

        // Hold: stall[2] and stall[3] both Stop keeps the addu in EX.
        issue(alu_bus(alu_tab[0]), alu_exp(alu_tab[0]), 1'b1);
        manual_stall      = 6'b001100;
        pipe.id_to_ex_bus = lw_b;
        @(posedge clk);
        sb.push_back(alu_exp(alu_tab[0]));
        @(negedge clk);
        // Bubble: stall[2] Stop with stall[3] NoStop zeroes the register.
        manual_stall = 6'b000100;
        @(posedge clk);
        sb.push_back(zero_e);
        @(negedge clk);
        manual_stall = 6'b000000;

        // Reset during cycle 10 of a divide.
        issue(div_b, zero_e, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        pipe.id_to_ex_bus = 159'h0;
        @(posedge clk);
        sb.push_back(zero_e);
        @(negedge clk);
        rst = 1'b0;

        repeat (5) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected responses never observed, 0 required", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
